// File: rtl/pen_lift_sequencer_pkg.sv
// Shared types and default sizing for the pen lift command sequencer.
package pen_lift_sequencer_pkg;

    typedef enum logic {
        SERVO_POS_UP   = 1'b0,
        SERVO_POS_DOWN = 1'b1
    } ServoPos_t;

    typedef enum logic [2:0] {
        IDLE,
        SKIP,
        ISSUE,
        WAIT,
        SETTLE,
        DONE
    } PenSeqState_t;

    localparam int          PEN_FIFO_DEPTH_BITS = 2;
    localparam int          PEN_SETTLE_BITS     = 16;
    localparam logic [15:0] PEN_SETTLE_COUNT    = 16'd5000;

endpackage

// File: rtl/pen_lift_sequencer_fifo.sv
// Small synchronous FIFO of pen positions. It pushes on any clock edge and pops only when the
// sequencer asks. Full and empty are derived from a registered occupancy count.
module pen_cmd_fifo
    import pen_lift_sequencer_pkg::*;
#(
    parameter int DEPTH_BITS = PEN_FIFO_DEPTH_BITS
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push_i,
    input  ServoPos_t push_pos_i,
    input  logic      pop_i,
    output logic      full_o,
    output logic      empty_o,
    output ServoPos_t head_o
);

    localparam int                  DEPTH      = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] COUNT_FULL = (DEPTH_BITS + 1)'(DEPTH);
    localparam logic [DEPTH_BITS:0] COUNT_ONE  = (DEPTH_BITS + 1)'(1);

    ServoPos_t             mem_q [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr_q;
    logic [DEPTH_BITS-1:0] rd_ptr_q;
    logic [DEPTH_BITS:0]   count_q;
    logic                  do_push;
    logic                  do_pop;

    // A push that coincides with a pop while full is still refused, because full is registered.
    assign full_o  = (count_q == COUNT_FULL);
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + COUNT_ONE;
                2'b01:   count_q <= count_q - COUNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is left unreset; an entry is only ever read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_pos_i;
    end

endmodule

// File: rtl/pen_lift_sequencer.sv
// Pen lift sequencer. It queues pen up/down requests, skips requests that match the known position,
// drives the servo handshake one move at a time, and reports completion after a settle delay.
module pen_lift_sequencer
    import pen_lift_sequencer_pkg::*;
#(
    parameter int                     DEPTH_BITS   = PEN_FIFO_DEPTH_BITS,
    parameter int                     SETTLE_BITS  = PEN_SETTLE_BITS,
    parameter logic [SETTLE_BITS-1:0] SETTLE_COUNT = SETTLE_BITS'(PEN_SETTLE_COUNT)
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      clk_en,
    input  logic      cmd_valid,
    input  ServoPos_t cmd_pos,
    output logic      cmd_rdy,
    output logic      cmd_done,
    output logic      busy,
    output ServoPos_t cur_pos,
    output logic      pos_known,
    output logic      servo_trigger,
    output ServoPos_t servo_pos,
    input  logic      servo_done,
    input  logic      servo_rdy
);

    localparam logic [SETTLE_BITS-1:0] SETTLE_LAST = SETTLE_COUNT - SETTLE_BITS'(1);

    PenSeqState_t           state_q, state_d;
    logic [SETTLE_BITS-1:0] settle_cnt_q, settle_cnt_d;
    ServoPos_t              servo_pos_q, servo_pos_d;
    ServoPos_t              cur_pos_q, cur_pos_d;
    logic                   pos_known_q, pos_known_d;
    logic                   trigger_q, trigger_d;
    logic                   done_q, done_d;

    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    ServoPos_t              fifo_head;

    pen_cmd_fifo #(
        .DEPTH_BITS (DEPTH_BITS)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (cmd_valid),
        .push_pos_i (cmd_pos),
        .pop_i      (fifo_pop),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .head_o     (fifo_head)
    );

    // NOTE: every signal gets its hold value first so no path through this block infers a latch.
    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        servo_pos_d  = servo_pos_q;
        cur_pos_d    = cur_pos_q;
        pos_known_d  = pos_known_q;
        trigger_d    = trigger_q;
        done_d       = done_q;
        fifo_pop     = 1'b0;

        if (clk_en) begin
            // Strobes are registered from the state being left, so each spans one clk_en period.
            trigger_d = (state_q == ISSUE);
            done_d    = (state_q == SKIP) || (state_q == DONE);

            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        if (pos_known_q && (fifo_head == cur_pos_q)) begin
                            fifo_pop = 1'b1;
                            state_d  = SKIP;
                        end else if (servo_rdy) begin
                            servo_pos_d = fifo_head;
                            fifo_pop    = 1'b1;
                            state_d     = ISSUE;
                        end
                    end
                end
                SKIP:  state_d = IDLE;
                ISSUE: state_d = WAIT;
                WAIT: begin
                    if (servo_done) begin
                        settle_cnt_d = '0;
                        state_d      = (SETTLE_COUNT == '0) ? DONE : SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_cnt_q == SETTLE_LAST) begin
                        state_d = DONE;
                    end else begin
                        settle_cnt_d = settle_cnt_q + SETTLE_BITS'(1);
                    end
                end
                DONE: begin
                    cur_pos_d   = servo_pos_q;
                    pos_known_d = 1'b1;
                    state_d     = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            settle_cnt_q <= '0;
            servo_pos_q  <= SERVO_POS_UP;
            cur_pos_q    <= SERVO_POS_UP;
            pos_known_q  <= 1'b0;
            trigger_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            servo_pos_q  <= servo_pos_d;
            cur_pos_q    <= cur_pos_d;
            pos_known_q  <= pos_known_d;
            trigger_q    <= trigger_d;
            done_q       <= done_d;
        end
    end

    assign cmd_rdy       = !fifo_full;
    assign busy          = !fifo_empty || (state_q != IDLE);
    assign cmd_done      = done_q;
    assign servo_trigger = trigger_q;
    assign servo_pos     = servo_pos_q;
    assign cur_pos       = cur_pos_q;
    assign pos_known     = pos_known_q;

endmodule
